// File: rtl/byte_shift_sequencer.sv
// byte_shift_sequencer: multi-cycle byte shifter/rotator, one bit per clock, valid/ready on both sides.
// Optional BYTE_SHIFT_BACK2BACK_EN lets a retiring result and a new request share one edge.
module byte_shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             carry_q, carry_d, out_valid_q, accept;
`ifdef BYTE_SHIFT_BACK2BACK_EN
    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
`else
    assign in_ready = rst_n & (state_q == IDLE);
`endif
    assign accept = in_valid & in_ready;
    // op[0] selects right vs left, op[1] selects rotate vs logical fill
    always_comb begin
        work_d  = op_q[0] ? {op_q[1] & work_q[0], work_q[WIDTH-1:1]}
                          : {work_q[WIDTH-2:0], op_q[1] & work_q[WIDTH-1]};
        carry_d = op_q[0] ? work_q[0] : work_q[WIDTH-1];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            work_q      <= in_data;
            op_q        <= in_op;
            cnt_q       <= in_amt;
            carry_q     <= 1'b0;
            state_q     <= (in_amt == '0) ? DONE : SHIFT;
            out_valid_q <= (in_amt == '0);
        end else if (state_q == SHIFT) begin
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == AMT_W'(1)) begin
                state_q     <= DONE;
                out_valid_q <= 1'b1;
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = work_q;
    assign out_carry = carry_q;
    assign out_zero  = ~|work_q;
endmodule

// File: tb/tb_byte_shift_sequencer.sv
// tb_byte_shift_sequencer: randomized and directed checks against an arithmetic shift/rotate model.
// Back-to-back scenario follows BYTE_SHIFT_BACK2BACK_EN when defined.
module tb_byte_shift_sequencer;
    logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic [2:0] in_amt = 0;
    logic [1:0] in_op = 0;
    logic       in_ready, out_valid, out_carry, out_zero;
    logic [7:0] out_data;
    int checks = 0, failures = 0;

    byte_shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] d, input logic [1:0] op, input int a,
                                  output logic [7:0] r, output logic c);
        int x, y, cc;
        x = d;
        cc = 0;
        case (op)
            2'd0: begin y = (x << a) & 255; if (a != 0) cc = x >> (8 - a); end
            2'd1: begin y = x >> a; if (a != 0) cc = x >> (a - 1); end
            2'd2: begin y = ((x << a) | (x >> (8 - a))) & 255; if (a != 0) cc = y; end
            default: begin y = ((x >> a) | (x << (8 - a))) & 255; if (a != 0) cc = y >> 7; end
        endcase
        r = y[7:0];
        c = cc[0];
    endfunction

    task automatic scramble();
        in_data  = 8'($urandom);
        in_op    = 2'($urandom);
        in_amt   = 3'($urandom);
        in_valid = 1'($urandom);
    endtask

    task automatic run_op(input logic [7:0] d, input logic [1:0] op, input logic [2:0] a, input int stall);
        logic [7:0] er;
        logic ec;
        int lat;
        bit seen;
        model(d, op, int'(a), er, ec);
        in_data = d; in_op = op; in_amt = a; in_valid = 1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
        @(posedge clk); @(negedge clk);
        scramble();
        lat = 1; seen = 0;
        while (!seen && lat <= 20) begin
            if (out_valid === 1'b1) seen = 1;
            else begin @(posedge clk); @(negedge clk); lat++; scramble(); end
        end
        checks++;
        if (!seen || lat != int'(a) + 1) begin
            failures++; $display("FAIL latency op=%0d amt=%0d got=%0d exp=%0d", op, a, lat, int'(a) + 1);
        end
        if (!seen) begin in_valid = 0; return; end
        checks++;
        if (out_data !== er || out_carry !== ec || out_zero !== (er == 8'h00) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL result d=%h op=%0d amt=%0d got=%h/%b/%b/%b exp=%h/%b/%b/0",
                     d, op, a, out_data, out_carry, out_zero, in_ready, er, ec, er == 8'h00);
        end
        repeat (stall) begin
            @(posedge clk); @(negedge clk);
            scramble();
            checks++;
            if (out_valid !== 1'b1 || out_data !== er || out_carry !== ec || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got=%b/%h/%b/%b exp=1/%h/%b/0", out_valid, out_data, out_carry, in_ready, er, ec);
            end
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL handshake got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_carry !== 1'b0 || out_zero !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset got=%b/%h/%b/%b/%b exp=0/00/0/1/0", out_valid, out_data, out_carry, out_zero, in_ready);
        end
        rst_n = 1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(8'h81, 2'd0, 3'd1, 0);
        run_op(8'h01, 2'd1, 3'd1, 0);
        run_op(8'h81, 2'd2, 3'd3, 0);
        run_op(8'h01, 2'd3, 3'd7, 0);
        run_op(8'h5A, 2'd0, 3'd0, 0);
        run_op(8'hA5, 2'd3, 3'd0, 1);
    endtask

    task automatic test_stall();
        run_op(8'hC3, 2'd1, 3'd4, 5);
        run_op(8'h80, 2'd0, 3'd1, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            run_op(8'($urandom), 2'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_mid();
        in_data = 8'hFF; in_op = 2'd0; in_amt = 3'd7; in_valid = 1;
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst_n = 0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_carry !== 1'b0 || out_zero !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b/%h/%b/%b/%b exp=0/00/0/1/0", out_valid, out_data, out_carry, out_zero, in_ready);
        end
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'($urandom); b = ~a;
        in_data = a; in_op = 2'd0; in_amt = 3'd0; in_valid = 1;
        @(posedge clk); @(negedge clk);
        in_data = b; out_ready = 1;
`ifdef BYTE_SHIFT_BACK2BACK_EN
        checks++;
        if (out_valid !== 1'b1 || out_data !== a || in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_first got=%b/%h/%b exp=1/%h/1", out_valid, out_data, in_ready, a);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== b) begin
            failures++; $display("FAIL b2b_second got=%b/%h exp=1/%h", out_valid, out_data, b);
        end
        @(posedge clk); @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
`else
        checks++;
        if (out_valid !== 1'b1 || out_data !== a || in_ready !== 1'b0) begin
            failures++; $display("FAIL bubble_done got=%b/%h/%b exp=1/%h/0", out_valid, out_data, in_ready, a);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bubble_idle got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        out_ready = 0;
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== b) begin
            failures++; $display("FAIL bubble_second got=%b/%h exp=1/%h", out_valid, out_data, b);
        end
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
